// File: rtl/fixedpoint_accumulator_pkg.sv
// Shared types and constants for the fixed-point batch accumulator.
// Terms are signed Q6.9; the accumulator keeps the same 9 fraction bits.
package fixedpoint_accumulator_pkg;

  localparam int WIDTH_INPUT_DEFAULT = 16;
  localparam int WIDTH_ACC_DEFAULT   = 32;
  localparam int WIDTH_LEN_DEFAULT   = 8;
  localparam int FRAC_BITS           = 9;

  localparam logic [15:0] ONE = 16'h0200;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/fixedpoint_accumulator_if.sv
// Term-in / sum-out stream bundle; signal names are seen from the accumulator.
interface fixedpoint_accumulator_if
  import fixedpoint_accumulator_pkg::*;
#(
  parameter int WIDTH_INPUT = WIDTH_INPUT_DEFAULT,
  parameter int WIDTH_ACC   = WIDTH_ACC_DEFAULT,
  parameter int WIDTH_LEN   = WIDTH_LEN_DEFAULT
);

  logic [WIDTH_LEN-1:0]          len_i;
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic signed [WIDTH_INPUT-1:0] in_data_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic signed [WIDTH_ACC-1:0]   out_data_o;
  logic                          out_ovf_o;

  modport master (
    output len_i, in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_ovf_o
  );

  modport slave (
    input  len_i, in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_ovf_o
  );

endinterface

// File: rtl/fixedpoint_adder.sv
// Combinational two's-complement adder; the result wraps to WIDTH_OUTPUT bits.
module fixedpoint_adder #(
  parameter int WIDTH_INPUT  = 32,
  parameter int WIDTH_OUTPUT = 32
) (
  input  logic signed [WIDTH_INPUT-1:0]  a_i,
  input  logic signed [WIDTH_INPUT-1:0]  b_i,
  output logic signed [WIDTH_OUTPUT-1:0] sum_o
);

  logic signed [WIDTH_INPUT:0] full_sum;

  assign full_sum = {a_i[WIDTH_INPUT-1], a_i} + {b_i[WIDTH_INPUT-1], b_i};
  assign sum_o    = WIDTH_OUTPUT'(full_sum);

endmodule

// File: rtl/fixedpoint_accumulator.sv
// Sums a batch of len_i+1 signed Q6.9 terms into a wrapping accumulator and
// presents the total with a sticky signed-overflow flag on a valid/ready port.
module fixedpoint_accumulator
  import fixedpoint_accumulator_pkg::*;
#(
  parameter int WIDTH_INPUT = WIDTH_INPUT_DEFAULT,
  parameter int WIDTH_ACC   = WIDTH_ACC_DEFAULT,
  parameter int WIDTH_LEN   = WIDTH_LEN_DEFAULT
) (
  input logic                     clk_i,
  input logic                     rst_i,
  input logic                     clr_i,
  fixedpoint_accumulator_if.slave bus
);

  state_t                      state_q, state_d;
  logic signed [WIDTH_ACC-1:0] acc_q, acc_d;
  logic [WIDTH_LEN-1:0]        cnt_q, cnt_d;
  logic                        ovf_q, ovf_d;

  logic                        beat;
  logic signed [WIDTH_ACC-1:0] term_ext;
  logic signed [WIDTH_ACC-1:0] sum;
  logic                        add_ovf;

  function automatic logic signed [WIDTH_ACC-1:0] sext_term(
    input logic signed [WIDTH_INPUT-1:0] t
  );
    return WIDTH_ACC'(t);
  endfunction

  assign term_ext = sext_term(bus.in_data_i);

  fixedpoint_adder #(
    .WIDTH_INPUT  (WIDTH_ACC),
    .WIDTH_OUTPUT (WIDTH_ACC)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (term_ext),
    .sum_o (sum)
  );

  // Same-sign operands producing an opposite-sign result is a signed wrap.
  assign add_ovf = (acc_q[WIDTH_ACC-1] == term_ext[WIDTH_ACC-1]) &&
                   (sum[WIDTH_ACC-1] != acc_q[WIDTH_ACC-1]);

  assign bus.in_ready_o  = (state_q != DONE) && !clr_i;
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.out_data_o  = acc_q;
  assign bus.out_ovf_o   = ovf_q;
  assign beat            = bus.in_valid_i && bus.in_ready_o;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (beat) begin
            acc_d   = term_ext;
            ovf_d   = 1'b0;
            cnt_d   = bus.len_i;
            state_d = (bus.len_i == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc_d = sum;
            ovf_d = ovf_q | add_ovf;
            cnt_d = cnt_q - WIDTH_LEN'(1);
            if (cnt_q == WIDTH_LEN'(1)) state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
